// File: rtl/answer_mem_writer.sv
// answer_mem_writer
//   Fills the answer memory with a pseudo-random sequence. When a start request
//   is accepted, it seeds an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) and then
//   writes DEPTH consecutive words, one per clock, from address 0. After the
//   last write it pulses done for one cycle.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; seed and address are loaded on accept
//   WRITE  | one word per cycle, data is lfsr[DATA_W-1:0], addr counts up
//   DONE   | one-cycle done pulse; always returns to IDLE
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_start      level-sampled fill request, honoured only in IDLE
//   i_seed       LFSR seed, sampled on the edge that accepts start
//   o_mem_we     answer memory write enable
//   o_mem_addr   answer memory write address
//   o_mem_din    answer memory write data
//   o_busy       high while a fill is in progress
//   o_done       one-cycle pulse after the last write
module answer_mem_writer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_seed,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_DEFAULT = 8'hA5;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_lfsr;
  logic [7:0]        w_lfsr_next;
  logic              w_last;

  assign w_last      = (r_addr == ADDR_W'(DEPTH - 1));
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_WRITE;
      S_WRITE: if (w_last)  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Address counter and LFSR. A zero seed would lock the LFSR, so it is
  // replaced by the default pattern. The LFSR does not step on the last
  // write; it is reloaded on the next accepted start anyway.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr <= '0;
      r_lfsr <= LFSR_DEFAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr <= '0;
            r_lfsr <= (i_seed == 8'h00) ? LFSR_DEFAULT : i_seed;
          end
        end
        S_WRITE: begin
          if (!w_last) begin
            r_addr <= r_addr + 1'b1;
            r_lfsr <= w_lfsr_next;
          end
        end
        default: begin
          r_addr <= r_addr;
          r_lfsr <= r_lfsr;
        end
      endcase
    end
  end

  // Output decode: driven only by registers, no input-to-output path.
  // Address and data are forced to zero outside WRITE so the bus is quiet
  // (and matches the reset values) whenever no write is in progress.
  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_din  = '0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_WRITE: begin
        o_mem_we   = 1'b1;
        o_busy     = 1'b1;
        o_mem_addr = r_addr;
        o_mem_din  = r_lfsr[DATA_W-1:0];
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: begin
        o_mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_answer_mem_writer.sv
module tb_answer_mem_writer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        seed;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  answer_mem_writer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_seed     (seed),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_din  (mem_din),
    .o_busy     (busy),
    .o_done     (done)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic       we;
    logic [3:0] addr;
    logic [3:0] din;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: position within a fill (-1 idle, 0..DEPTH-1 writing,
  // DEPTH = done cycle) plus the seed that started the fill.
  int         m_pos = -1;
  logic [7:0] m_seed = 8'h00;

  logic [3:0] mem [DEPTH];
  int wr_count, done_count, last_wr_cyc, done_cyc;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  // Word number idx of the sequence generated from seed s.
  function automatic logic [3:0] exp_word(input logic [7:0] s, input int idx);
    logic [7:0] l;
    l = (s == 8'h00) ? 8'hA5 : s;
    for (int k = 0; k < idx; k++) l = lfsr_next(l);
    return l[3:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one clock: update the model with the inputs seen at this edge,
  // then sample the DUT 1 time unit after the edge and compare.
  task automatic step();
    logic exp_we;
    if (rst) m_pos = -1;
    else if (m_pos == -1) begin
      if (start) begin
        m_pos  = 0;
        m_seed = seed;
      end
    end else if (m_pos == DEPTH) m_pos = -1;
    else m_pos++;

    @(posedge clk);
    #1;
    cyc++;

    exp_we = (m_pos >= 0) && (m_pos < DEPTH);
    chk("model_we",   32'(mem_we), 32'(exp_we));
    chk("model_busy", 32'(busy),   32'(exp_we));
    chk("model_done", 32'(done),   32'(m_pos == DEPTH));
    if (exp_we) begin
      chk("model_addr", 32'(mem_addr), 32'(m_pos));
      chk("model_din",  32'(mem_din),  32'(exp_word(m_seed, m_pos)));
    end

    if (mem_we === 1'b1) begin
      mem[mem_addr] = mem_din;
      wr_count++;
      last_wr_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_counts();
    wr_count = 0;
    done_count = 0;
    last_wr_cyc = -1;
    done_cyc = -1;
  endtask

  // Step until done is seen, bounded.
  task automatic wait_done(input string name, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done === 1'b1), 32'd1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (m_pos != -1 && n < limit) begin
      step();
      n++;
    end
    chk("drain_idle", 32'(m_pos == -1), 32'd1);
  endtask

  initial begin
    int gap_viol;
    logic prev_done;
    int n;

    rst = 1'b1;
    start = 1'b0;
    seed = 8'h00;
    clear_counts();

    //          rst   start seed   we    addr  din   busy  done
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h01, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 4'h0, 4'h1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 1'b1, 4'h1, 4'h2, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h33, 1'b1, 4'h2, 4'h4, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h3, 4'h8, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h4, 4'h1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'h5, 4'h3, 1'b1, 1'b0};

    // Reset, rst-beats-start, then seed 8'h01 fill with mid-fill seed changes
    for (int i = 0; i < 8; i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      seed  = vecs[i].seed;
      step();
      chk("tbl_we",   32'(mem_we),   32'(vecs[i].we));
      chk("tbl_addr", 32'(mem_addr), 32'(vecs[i].addr));
      chk("tbl_din",  32'(mem_din),  32'(vecs[i].din));
      chk("tbl_busy", 32'(busy),     32'(vecs[i].busy));
      chk("tbl_done", 32'(done),     32'(vecs[i].done));
    end
    start = 1'b0;
    wait_done("fill1", 40);
    chk("fill1_writes", 32'(wr_count), 32'(DEPTH));
    chk("fill1_done_after_last", 32'(done_cyc - last_wr_cyc), 32'd1);
    for (int i = 0; i < DEPTH; i++) chk("fill1_mem", 32'(mem[i]), 32'(exp_word(8'h01, i)));
    step();
    step();
    chk("fill1_one_done", 32'(done_count), 32'd1);

    // Zero seed replaced by 8'hA5
    clear_counts();
    start = 1'b1;
    seed = 8'h00;
    step();
    start = 1'b0;
    chk("seed0_addr", 32'(mem_addr), 32'd0);
    chk("seed0_din",  32'(mem_din),  32'h5);
    wait_done("seed0", 40);
    chk("seed0_writes", 32'(wr_count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) chk("seed0_mem", 32'(mem[i]), 32'(exp_word(8'hA5, i)));
    drain(5);

    // start held high for 40 cycles: back-to-back fills with an idle gap
    clear_counts();
    gap_viol = 0;
    prev_done = 1'b0;
    start = 1'b1;
    seed = 8'h5C;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev_done && mem_we === 1'b1) gap_viol++;
      prev_done = (done === 1'b1);
    end
    start = 1'b0;
    drain(40);
    chk("b2b_done_count", 32'(done_count), 32'd3);
    chk("b2b_writes", 32'(wr_count), 32'(3 * DEPTH));
    chk("b2b_gap", 32'(gap_viol), 32'd0);

    // Reset after the addr 6 write
    clear_counts();
    start = 1'b1;
    seed = 8'h37;
    step();
    start = 1'b0;
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 4'd6) && n < 20) begin
      step();
      n++;
    end
    chk("rst_mid_reached_addr6", 32'(mem_addr), 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_we",   32'(mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy),   32'd0);
    for (int i = 0; i < 20; i++) step();
    chk("rst_mid_no_done", 32'(done_count), 32'd0);
    chk("rst_mid_writes",  32'(wr_count),   32'd7);
    start = 1'b1;
    seed = 8'h01;
    step();
    start = 1'b0;
    chk("restart_we",   32'(mem_we),   32'd1);
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("restart_din",  32'(mem_din),  32'd1);
    drain(40);

    // Randomized inputs against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) == 0);
      seed  = 8'($urandom);
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    drain(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
